// File: rtl/icache.sv
// ----------------------------------------------------------------------------
// icache -- direct-mapped instruction cache
//
// Sits between the instruction fetcher and the memory controller. A hit returns
// one 32-bit little-endian instruction the cycle after the request. A miss
// issues a full-line fill request, installs the returned line, and forwards the
// requested word straight from the fill data.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global ready; 0 freezes all state (fe_valid reads 0)
//   rollback        pipeline flush: cancels the delivery in progress
//   fe_req, fe_pc   fetch request and its address (bits [1:0] ignored)
//   fe_valid        one-cycle pulse, fe_inst carries the requested word
//   fe_inst         instruction word
//   mc_en, mc_pc    line-fill request and line-aligned address, held until done
//   mc_done         one-cycle pulse, mc_data holds the requested line
//   mc_data         line data, byte i at bits [8i+7:8i]
//
// Optional build macro ICACHE_PERF_EN adds hit_cnt / miss_cnt outputs
// (32-bit wrapping counters of served hits and of fill requests started).
// ----------------------------------------------------------------------------
module icache #(
  parameter int LINE_BYTES = 16,
  parameter int LINES      = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    fe_req,
  input  logic [ADDR_W-1:0]       fe_pc,
  output logic                    fe_valid,
  output logic [31:0]             fe_inst,
  output logic                    mc_en,
  output logic [ADDR_W-1:0]       mc_pc,
  input  logic                    mc_done,
  input  logic [LINE_BYTES*8-1:0] mc_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
`endif
);

  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int IDX    = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - OFF - IDX;
  localparam int LINE_W = LINE_BYTES * 8;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINE_W-1:0]   data_q [LINES];
  logic                fe_valid_q, fe_valid_d;
  logic [31:0]         fe_inst_q, fe_inst_d;
  logic                mc_en_q, mc_en_d;
  logic [ADDR_W-1:0]   mc_pc_q, mc_pc_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic                cancel_q, cancel_d;
  logic                fill_we;

  logic [IDX-1:0]      fe_idx, req_idx;
  logic [TAG_W-1:0]    fe_tag, req_tag;
  logic                fe_hit;

  // Pick the 32-bit word addressed by a byte offset; the two low offset bits
  // are dropped so any byte address inside a word selects that word.
  function automatic logic [31:0] select_word(input logic [LINE_W-1:0] line,
                                              input logic [OFF-1:0]    off);
    logic [OFF-1:0] woff;
    woff      = off;
    woff[1:0] = 2'b00;
    return line[{woff, 3'b000} +: 32];
  endfunction

  assign fe_idx  = fe_pc[OFF+IDX-1:OFF];
  assign fe_tag  = fe_pc[ADDR_W-1:OFF+IDX];
  assign req_idx = req_pc_q[OFF+IDX-1:OFF];
  assign req_tag = req_pc_q[ADDR_W-1:OFF+IDX];
  assign fe_hit  = valid_q[fe_idx] && (tag_q[fe_idx] == fe_tag);

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    fe_valid_d = 1'b0;
    fe_inst_d  = fe_inst_q;
    mc_en_d    = mc_en_q;
    mc_pc_d    = mc_pc_q;
    req_pc_d   = req_pc_q;
    cancel_d   = cancel_q;
    fill_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Stray mc_done pulses are deliberately not looked at here.
        if (fe_req && !rollback) begin
          if (fe_hit) begin
            fe_valid_d = 1'b1;
            fe_inst_d  = select_word(data_q[fe_idx], fe_pc[OFF-1:0]);
          end else begin
            req_pc_d = fe_pc;
            mc_en_d  = 1'b1;
            mc_pc_d  = {fe_pc[ADDR_W-1:OFF], {OFF{1'b0}}};
            cancel_d = 1'b0;
            state_d  = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (rollback) begin
          cancel_d = 1'b1;
        end
        // The burst cannot be aborted, so the line is always installed; only
        // the delivery to the fetcher is suppressed once cancelled (including
        // a rollback arriving in the same cycle as mc_done).
        if (mc_done) begin
          fill_we          = 1'b1;
          valid_d[req_idx] = 1'b1;
          mc_en_d          = 1'b0;
          state_d          = S_IDLE;
          if (!(cancel_q || rollback)) begin
            fe_valid_d = 1'b1;
            fe_inst_d  = select_word(mc_data, req_pc_q[OFF-1:0]);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; rdy=0 freezes everything but clears fe_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      fe_valid_q <= 1'b0;
      fe_inst_q  <= '0;
      mc_en_q    <= 1'b0;
      mc_pc_q    <= '0;
      req_pc_q   <= '0;
      cancel_q   <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      fe_valid_q <= fe_valid_d;
      fe_inst_q  <= fe_inst_d;
      mc_en_q    <= mc_en_d;
      mc_pc_q    <= mc_pc_d;
      req_pc_q   <= req_pc_d;
      cancel_q   <= cancel_d;
    end else begin
      fe_valid_q <= 1'b0;
    end
  end

  // Tag and data arrays, written only by a completed fill; never reset
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_we) begin
      data_q[req_idx] <= mc_data;
      tag_q[req_idx]  <= req_tag;
    end
  end

  assign fe_valid = fe_valid_q;
  assign fe_inst  = fe_inst_q;
  assign mc_en    = mc_en_q;
  assign mc_pc    = mc_pc_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // A hit is a delivery launched from IDLE; a miss is every entry into WAIT,
  // whether or not it is later cancelled.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      if (state_q == S_IDLE && fe_valid_d) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (state_q == S_IDLE && state_d == S_WAIT) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// ----------------------------------------------------------------------------
// tb_icache -- self-checking bench for icache.
// The memory behind the cache is a fixed function of the byte address, so the
// reference model only has to know which line address occupies each cache
// slot: any delivered word must equal the memory word at the fetch address.
// ----------------------------------------------------------------------------
module tb_icache;
  localparam int LB = 16;
  localparam int NL = 16;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          rollback;
  logic          fe_req;
  logic [31:0]   fe_pc;
  logic          fe_valid;
  logic [31:0]   fe_inst;
  logic          mc_en;
  logic [31:0]   mc_pc;
  logic          mc_done;
  logic [127:0]  mc_data;
`ifdef ICACHE_PERF_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  icache #(.LINE_BYTES(LB), .LINES(NL), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .fe_req   (fe_req),
    .fe_pc    (fe_pc),
    .fe_valid (fe_valid),
    .fe_inst  (fe_inst),
    .mc_en    (mc_en),
    .mc_pc    (mc_pc),
    .mc_done  (mc_done),
    .mc_data  (mc_data)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Backing memory: the line at 0x1000 holds bytes 0x00..0x0F, other lines
  // are offset by 37 per 256-byte block so neighbouring tags differ.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] t;
    t = (a >> 8) - 32'h10;
    return 8'(a[7:0] + 8'(t * 37));
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = a - (a % LB);
    for (int i = 0; i < LB; i++) l[8*i +: 8] = mem_byte(base + i);
    return l;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a - (a % 4);
    return {mem_byte(w + 3), mem_byte(w + 2), mem_byte(w + 1), mem_byte(w)};
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] rand_pc();
    return 32'h1000 + ($urandom_range(0, 2) * 256) + ($urandom_range(0, 15) * 16)
           + $urandom_range(0, 15);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_on = 1'b0;
  bit          res_v  [NL];
  logic [31:0] res_la [NL];
  bit          pend, pend_cancel;
  logic [31:0] pend_pc;
  logic        e_fv, e_en;
  logic [31:0] e_inst, e_pc;
  logic [31:0] m_hits, m_misses;
  int          m_ix;
  logic [31:0] m_la;

  always @(posedge clk) begin
    m_la = fe_pc - (fe_pc % LB);
    m_ix = int'((fe_pc / LB) % NL);
    if (rst) begin
      m_on = 1'b1;
      for (int i = 0; i < NL; i++) res_v[i] = 1'b0;
      pend = 1'b0; pend_cancel = 1'b0;
      e_fv = 1'b0; e_en = 1'b0; e_inst = '0; e_pc = '0;
      m_hits = '0; m_misses = '0;
    end else if (m_on) begin
      e_fv = 1'b0;
      if (rdy) begin
        if (!pend) begin
          if (fe_req && !rollback) begin
            if (res_v[m_ix] && res_la[m_ix] == m_la) begin
              e_fv = 1'b1; e_inst = mem_word(fe_pc); m_hits = m_hits + 1;
            end else begin
              pend = 1'b1; pend_cancel = 1'b0; pend_pc = fe_pc;
              e_en = 1'b1; e_pc = m_la; m_misses = m_misses + 1;
            end
          end
        end else begin
          if (rollback) pend_cancel = 1'b1;
          if (mc_done) begin
            m_ix = int'((pend_pc / LB) % NL);
            res_v[m_ix] = 1'b1;
            res_la[m_ix] = pend_pc - (pend_pc % LB);
            pend = 1'b0; e_en = 1'b0;
            if (!pend_cancel) begin
              e_fv = 1'b1; e_inst = mem_word(pend_pc);
            end
          end
        end
      end
    end
  end

  // Compare every cycle, mid-period
  always @(negedge clk) begin
    if (m_on) begin
      chk("fe_valid", 32'(fe_valid), 32'(e_fv));
      chk("fe_inst", fe_inst, e_inst);
      chk("mc_en", 32'(mc_en), 32'(e_en));
      chk("mc_pc", mc_pc, e_pc);
`ifdef ICACHE_PERF_EN
      chk("hit_cnt", hit_cnt, m_hits);
      chk("miss_cnt", miss_cnt, m_misses);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    mc_done = 1'b1;
    mc_data = mem_line(mc_pc);
    tick();
    mc_done = 1'b0;
    mc_data = rand_line();
  endtask

  initial begin
    int cnt;
    int lat;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; fe_req = 1'b0; fe_pc = '0;
    mc_done = 1'b0; mc_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset fe_valid", 32'(fe_valid), 32'h0);
    chk("reset mc_en", 32'(mc_en), 32'h0);
    chk("reset mc_pc", mc_pc, 32'h0);
    chk("reset fe_inst", fe_inst, 32'h0);

    // Cold miss
    fe_req = 1'b1; fe_pc = 32'h0000_1004;
    tick();
    chk("cold mc_en", 32'(mc_en), 32'h1);
    chk("cold mc_pc", mc_pc, 32'h0000_1000);
    chk("cold no valid", 32'(fe_valid), 32'h0);
    tick();
    chk("cold mc_en held", 32'(mc_en), 32'h1);
    fill();
    chk("cold fe_valid", 32'(fe_valid), 32'h1);
    chk("cold fe_inst", fe_inst, 32'h0706_0504);
    chk("cold mc_en drop", 32'(mc_en), 32'h0);

    // Hits after fill, back to back
    fe_pc = 32'h0000_100C;
    tick();
    chk("hit1 fe_valid", 32'(fe_valid), 32'h1);
    chk("hit1 fe_inst", fe_inst, 32'h0F0E_0D0C);
    fe_pc = 32'h0000_1000;
    tick();
    chk("hit2 fe_valid", 32'(fe_valid), 32'h1);
    chk("hit2 fe_inst", fe_inst, 32'h0302_0100);
    chk("hit2 mc_en", 32'(mc_en), 32'h0);
    fe_req = 1'b0;
    tick();
    chk("idle fe_valid", 32'(fe_valid), 32'h0);

    // Conflict eviction
    fe_req = 1'b1; fe_pc = 32'h0000_1100;
    tick();
    chk("conflict mc_en", 32'(mc_en), 32'h1);
    chk("conflict mc_pc", mc_pc, 32'h0000_1100);
    fill();
    chk("conflict fe_inst", fe_inst, 32'h2827_2625);
    fe_pc = 32'h0000_1000;
    tick();
    chk("evicted mc_en", 32'(mc_en), 32'h1);
    chk("evicted mc_pc", mc_pc, 32'h0000_1000);
    fill();
    chk("refill fe_inst", fe_inst, 32'h0302_0100);
    fe_req = 1'b0;
    tick();

    // Rollback during fill
    fe_req = 1'b1; fe_pc = 32'h0000_2000;
    tick();
    chk("rb mc_pc", mc_pc, 32'h0000_2000);
    fe_req = 1'b0;
    tick();
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    fill();
    chk("rb no fe_valid", 32'(fe_valid), 32'h0);
    chk("rb mc_en drop", 32'(mc_en), 32'h0);
    fe_req = 1'b1; fe_pc = 32'h0000_2000;
    tick();
    chk("rb line hit", 32'(fe_valid), 32'h1);
    chk("rb line inst", fe_inst, 32'h5352_5150);
    fe_req = 1'b0;
    tick();

    // Stall with mc_done held
    fe_req = 1'b1; fe_pc = 32'h0000_3010;
    tick();
    chk("stall mc_pc", mc_pc, 32'h0000_3010);
    rdy = 1'b0; mc_done = 1'b1; mc_data = mem_line(mc_pc);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall fe_valid", 32'(fe_valid), 32'h0);
      chk("stall mc_en", 32'(mc_en), 32'h1);
    end
    rdy = 1'b1;
    tick();
    mc_done = 1'b0; fe_req = 1'b0;
    chk("stall fill valid", 32'(fe_valid), 32'h1);
    chk("stall fill inst", fe_inst, 32'hB3B2_B1B0);
    tick();
    chk("stall single pulse", 32'(fe_valid), 32'h0);

    // Reset mid-fill
    fe_req = 1'b1; fe_pc = 32'h0000_4020;
    tick();
    chk("rstfill mc_en", 32'(mc_en), 32'h1);
    rst = 1'b1; fe_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstfill mc_en drop", 32'(mc_en), 32'h0);
`ifdef ICACHE_PERF_EN
    chk("rstfill hit_cnt", hit_cnt, 32'h0);
    chk("rstfill miss_cnt", miss_cnt, 32'h0);
`endif
    mc_done = 1'b1; mc_data = rand_line();
    tick();
    mc_done = 1'b0;
    chk("stray done mc_en", 32'(mc_en), 32'h0);
    chk("stray done fe_valid", 32'(fe_valid), 32'h0);
    fe_req = 1'b1; fe_pc = 32'h0000_4020;
    tick();
    chk("after rst miss", 32'(mc_en), 32'h1);
    chk("after rst mc_pc", mc_pc, 32'h0000_4020);
    fill();
    chk("after rst inst", fe_inst, 32'h1312_1110);
    fe_pc = 32'h0000_1000;
    tick();
    chk("flushed line miss", 32'(mc_en), 32'h1);
    fill();
    fe_req = 1'b0;
    tick();

    // Randomized traffic against the model
    cnt = 0;
    lat = 2;
    for (int c = 0; c < 5000; c++) begin
      rst      = ($urandom % 600 == 0);
      rdy      = ($urandom % 8 != 0);
      rollback = ($urandom % 15 == 0);
      if ($urandom % 3 == 0) fe_pc = rand_pc();
      fe_req   = ($urandom % 4 != 0);
      if (mc_en) begin
        cnt++;
        mc_done = (cnt > lat);
        mc_data = mc_done ? mem_line(mc_pc) : rand_line();
      end else begin
        cnt = 0;
        lat = $urandom_range(0, 4);
        mc_done = ($urandom % 16 == 0);
        mc_data = rand_line();
      end
      tick();
    end

    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; fe_req = 1'b0; mc_done = 1'b0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
